// File: rtl/ndn_prefix_tx.sv
// ndn_prefix_tx: framed bit-serial transmitter for NDN name prefixes.
// Sends a LEN_W-bit length header, then the prefix body, under backpressure.
module ndn_prefix_tx #(
  parameter int PREFIX_W  = 64,
  parameter int LEN_W     = 7,
  parameter int GAP       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PREFIX_W-1:0] in_prefix,
  input  logic [LEN_W-1:0]    in_len,
  output logic                out_bit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eof,
  output logic                err_len,
  output logic                busy
);
  localparam int CW = $clog2(PREFIX_W + LEN_W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GL = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [PREFIX_W-1:0] prefix_q, prefix_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;

  logic          accept;
  logic          len_bad;
  logic          fire;
  logic          hdr_last;
  logic          body_last;
  logic [CW-1:0] bidx;
  logic [CW-1:0] bsel;
  logic [CW-1:0] hsel;

  // One counter walks header then body; body index is offset by LEN_W.
  assign accept    = (state_q == S_IDLE) && in_valid && rdy_q;
  assign len_bad   = (in_len == '0) || (in_len > LEN_W'(PREFIX_W));
  assign fire      = out_valid && out_ready;
  assign hdr_last  = cnt_q == CW'(LEN_W - 1);
  assign body_last = cnt_q == (CW'(LEN_W) + CW'(len_q) - CW'(1));
  assign bidx      = cnt_q - CW'(LEN_W);
  assign bsel      = MSB_FIRST ? (CW'(len_q) - CW'(1) - bidx) : bidx;
  assign hsel      = CW'(LEN_W - 1) - cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      prefix_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prefix_d = prefix_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          prefix_d = in_prefix;
          len_d    = in_len;
          cnt_d    = '0;
          if (len_bad) err_d = 1'b1;
          else state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (fire) begin
          cnt_d = cnt_q + CW'(1);
          if (hdr_last) state_d = S_BODY;
        end
      end
      S_BODY: begin
        if (fire) begin
          cnt_d = cnt_q + CW'(1);
          if (body_last) begin
            cnt_d   = '0;
            gcnt_d  = '0;
            state_d = (GAP > 0) ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + GW'(1);
        if (gcnt_q == GW'(GL)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_comb begin
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    unique case (state_q)
      S_HDR: begin
        out_valid = 1'b1;
        out_bit   = |(len_q & (LEN_W'(1) << hsel));
        out_sof   = (cnt_q == '0);
      end
      S_BODY: begin
        out_valid = 1'b1;
        out_bit   = |(prefix_q & (PREFIX_W'(1) << bsel));
        out_eof   = body_last;
      end
      default: ;
    endcase
  end

  assign in_ready = rdy_q;
  assign err_len  = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/ndn_prefix_tx.md
# ndn_prefix_tx

Parametrised serial transmitter for NDN name prefixes in the router datapath. Accepts a prefix word plus bit length over a valid/ready handshake and emits a framed bit-serial stream: a length header, then the prefix bits. Frames are bracketed by start/end markers, and the output side honours sink backpressure. Used on the router's outgoing interest path and as a synthesizable stimulus source for `ndn` bring-up.

## Interface
- `PREFIX_W`, 64: prefix word width in bits.
- `LEN_W`, 7: width of the length field and the header; must satisfy 2^LEN_W > PREFIX_W.
- `GAP`, 2: idle cycles inserted after each frame; 0 is allowed.
- `MSB_FIRST`, 1: body bit order. 1 sends `in_prefix[len-1]` down to `[0]`. 0 sends `[0]` up to `[len-1]`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request to load a prefix.
- `in_ready`  out  1  block can accept; registered.
- `in_prefix`  in  PREFIX_W  prefix bits, right-aligned.
- `in_len`  in  LEN_W  number of valid prefix bits.
- `out_bit`  out  1  serial data.
- `out_valid`  out  1  `out_bit` is meaningful.
- `out_ready`  in  1  sink consumes the bit on this edge when `out_valid`.
- `out_sof`  out  1  high with the first header bit.
- `out_eof`  out  1  high with the last body bit.
- `err_len`  out  1  one-cycle pulse when a load is rejected.
- `busy`  out  1  state not IDLE.

## Operation
- States: IDLE, HDR, BODY, GAP.
- **IDLE**
  - `in_ready`=1.
  - Accept on `in_valid && in_ready`: latch prefix and length, clear the bit counter.
  - `in_len`==0 or `in_len`>PREFIX_W: no frame is sent. `err_len` pulses the next cycle, state stays IDLE, `in_ready` stays 1.
  - Valid length: go to HDR and drop `in_ready` on the same edge.
- **HDR**
  - Sends latched len over LEN_W bits, MSB first, regardless of MSB_FIRST.
  - `out_sof`=1 on header bit 0 only.
  - After the LEN_W-th handshake, go to BODY.
- **BODY**
  - Sends len prefix bits in MSB_FIRST order.
  - `out_eof`=1 on the last bit.
  - After the last handshake: go to GAP if GAP>0, else to IDLE.
- **GAP**
  - Counts GAP cycles with `out_valid`=0, then goes to IDLE.
- **Backpressure:** an output bit advances only on `out_valid && out_ready`. `out_bit`, `out_sof` and `out_eof` hold stable while stalled.
- The latched prefix and length are immune to input changes after acceptance.
- Bit counter width: clog2(PREFIX_W+LEN_W). No wrap occurs within a legal frame.
- **Reset (asserted, any time, mid-frame included):** immediately go to IDLE.
  - `in_ready`=0, `out_valid`=0, `out_bit`=0, `out_sof`=0, `out_eof`=0, `err_len`=0, `busy`=0, counters=0.
  - The frame in progress is abandoned, not resumed.
  - `in_ready` rises on the first `clk` edge after `rst` deasserts.

## Timing
- Load accepted at edge N: `out_valid`=1 with header bit 0 from edge N to N+1 (one-cycle latency). `err_len`, when it fires, is likewise high from edge N to N+1.
- With `out_ready` held 1, a frame lasts LEN_W+len cycles, followed by GAP idle cycles. `in_ready` returns at edge N+LEN_W+len+GAP.
- Back-to-back throughput: one frame per LEN_W+len+GAP+1 cycles. The extra cycle is the IDLE accept cycle.
- Each stall cycle extends the frame by exactly one cycle.
- `in_valid` while `in_ready`=0 is ignored. The source holds its request until accepted.
- `out_sof` and `out_eof` are never high in the same cycle, since len≥1 and LEN_W≥1.

## Test plan
- **Basic frame:** defaults, `in_prefix`=28, `in_len`=5, `out_ready`=1.
  - Required stream: 0,0,0,0,1,0,1 then 1,1,1,0,0.
  - `out_sof` on the 1st bit, `out_eof` on the 12th.
  - `in_ready` returns 14 cycles after accept (12 frame + 2 gap).
- **Backpressure:** same load, `out_ready` low on every other cycle.
  - Same 12-bit sequence, no bit duplicated or skipped.
  - Frame spans 24 cycles; outputs hold during stalls.
- **Length errors:** `in_len`=0, then `in_len`=65.
  - One `err_len` pulse each, no `out_valid`, `in_ready` stays 1.
  - `in_len`=64 with all-ones prefix sends 71 bits, the last 64 all 1.
- **Back-to-back and bit order:** `MSB_FIRST`=0, GAP=0, loads (0x6,3) then (0x1,1).
  - Bodies 0,1,1 and 1.
  - Second `out_sof` one cycle after first `out_eof` + accept cycle.
- **Reset mid-frame:** assert `rst` during BODY bit 3.
  - All outputs 0 asynchronously.
  - After release, a new load (0xA,4) sends header 0000100 and body 1,0,1,0 cleanly.
- **Input change after accept:** alter `in_prefix`/`in_len` during HDR; the transmitted frame is unchanged.
